// File: rtl/operand_entry.sv
// -----------------------------------------------------------------------------
// operand_entry
//
// Front end for a push-button / DIP-switch ALU trainer.  Two raw keys (Enter,
// Run) are synchronised and debounced into single-cycle press events.  Enter
// writes hex nibbles into two 16-bit operand latches (AL, BL) or changes the
// entry mode.  Run hands the latched operands and an opcode to the ALU.
//
// Optional feature macro: OPERAND_SIGN_EXT_EN
//   defined   -> a_out / b_out are AL / BL sign-extended from bit 15
//   undefined -> a_out / b_out are AL / BL zero-extended to 32 bits
//
// Parameters
//   DB_CYCLES  consecutive stable cycles needed to accept a key level change
//   DB_W       debounce counter width (DB_CYCLES < 2**DB_W)
//
// Ports
//   clk          system clock, all state changes on the rising edge
//   rst_n        synchronous active-low reset
//   key_enter_n  raw Enter button, asynchronous, low = pressed
//   key_run_n    raw Run button, asynchronous, low = pressed
//   sw_sel       0 = operand A, 1 = operand B, 2/3 = show result
//   sw_digit     hex nibble to enter
//   sw_oper      opcode issued on Run
//   alu_result   ALU result, shown on the display in SHOW_RES
//   a_out        operand A to the ALU
//   b_out        operand B to the ALU
//   oper_out     opcode to the ALU
//   run_pulse    one-cycle strobe, high in the cycle after a_out/b_out/oper_out load
//   disp_data    value for the four hex digits (one cycle behind the source)
//   mode         FSM state: 0 = ENTRY_A, 1 = ENTRY_B, 2 = SHOW_RES
//   nib_idx      index of the next nibble to be written
// -----------------------------------------------------------------------------
module operand_entry #(
  parameter int DB_CYCLES = 50000,
  parameter int DB_W      = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_enter_n,
  input  logic        key_run_n,
  input  logic [1:0]  sw_sel,
  input  logic [3:0]  sw_digit,
  input  logic [2:0]  sw_oper,
  input  logic [15:0] alu_result,
  output logic [31:0] a_out,
  output logic [31:0] b_out,
  output logic [2:0]  oper_out,
  output logic        run_pulse,
  output logic [15:0] disp_data,
  output logic [1:0]  mode,
  output logic [1:0]  nib_idx
);

  typedef enum logic [1:0] {
    ENTRY_A  = 2'd0,
    ENTRY_B  = 2'd1,
    SHOW_RES = 2'd2
  } state_t;

  // Counter value on which the next differing cycle completes the debounce.
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE  = {{(DB_W-1){1'b0}}, 1'b1};
  localparam logic [DB_W-1:0] DB_ZERO = {DB_W{1'b0}};

  // Key index 0 = Enter, 1 = Run.
  localparam int KEY_ENTER = 0;
  localparam int KEY_RUN   = 1;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------

  // Replace nibble idx of a 16-bit latch with a new digit.
  function automatic logic [15:0] set_nibble(input logic [15:0] val,
                                             input logic [1:0]  idx,
                                             input logic [3:0]  dig);
    logic [15:0] res;
    res = val;
    case (idx)
      2'd0:    res[3:0]   = dig;
      2'd1:    res[7:4]   = dig;
      2'd2:    res[11:8]  = dig;
      2'd3:    res[15:12] = dig;
      default: res        = val;
    endcase
    return res;
  endfunction

  // Widen a 16-bit operand latch to the 32-bit ALU operand.
  function automatic logic [31:0] ext_operand(input logic [15:0] val);
`ifdef OPERAND_SIGN_EXT_EN
    return {{16{val[15]}}, val};
`else
    return {16'h0000, val};
`endif
  endfunction

  // ---------------------------------------------------------------------------
  // Synchroniser + debouncer, one lane per key
  // ---------------------------------------------------------------------------
  logic [1:0]      raw_s;
  logic [1:0]      sync1_r;
  logic [1:0]      sync2_r;
  logic [1:0]      level_r;     // debounced level, 1 = released
  logic [1:0]      level_d_r;   // debounced level one cycle earlier
  logic [DB_W-1:0] cnt_r [2];
  logic [1:0]      press_s;
  logic            enter_evt_s;
  logic            run_evt_s;

  assign raw_s = {key_run_n, key_enter_n};

  // Two-flop synchronisers, debounce counters and debounced levels.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_r   <= 2'b11;
      sync2_r   <= 2'b11;
      level_r   <= 2'b11;
      level_d_r <= 2'b11;
      for (int i = 0; i < 2; i++) begin
        cnt_r[i] <= DB_ZERO;
      end
    end else begin
      sync1_r   <= raw_s;
      sync2_r   <= sync1_r;
      level_d_r <= level_r;
      for (int i = 0; i < 2; i++) begin
        // Any cycle where the synchronised level agrees with the debounced
        // level clears the count, so a glitch restarts the qualification.
        if (sync2_r[i] != level_r[i]) begin
          if (cnt_r[i] == DB_LAST) begin
            level_r[i] <= sync2_r[i];
            cnt_r[i]   <= DB_ZERO;
          end else begin
            cnt_r[i]   <= cnt_r[i] + DB_ONE;
          end
        end else begin
          cnt_r[i] <= DB_ZERO;
        end
      end
    end
  end

  // A press is the debounced 1->0 transition; it is high for the single cycle
  // after the debounced level falls and is consumed on the following edge.
  assign press_s     = level_d_r & ~level_r;
  assign enter_evt_s = press_s[KEY_ENTER];
  assign run_evt_s   = press_s[KEY_RUN];

  // ---------------------------------------------------------------------------
  // Entry FSM and operand latches
  // ---------------------------------------------------------------------------
  state_t      state_r;
  state_t      state_nxt_s;
  state_t      target_s;
  logic [1:0]  nib_r;
  logic [1:0]  nib_nxt_s;
  logic [15:0] al_r;
  logic [15:0] al_nxt_s;
  logic [15:0] bl_r;
  logic [15:0] bl_nxt_s;

  // Map the mode switches onto the state they select.
  always_comb begin
    target_s = SHOW_RES;
    case (sw_sel)
      2'd0:    target_s = ENTRY_A;
      2'd1:    target_s = ENTRY_B;
      default: target_s = SHOW_RES;
    endcase
  end

  // Next-state, nibble index and latch update on an Enter event.
  always_comb begin
    state_nxt_s = state_r;
    nib_nxt_s   = nib_r;
    al_nxt_s    = al_r;
    bl_nxt_s    = bl_r;
    if (enter_evt_s) begin
      if (target_s != state_r) begin
        // Mode change only: no latch is written.
        state_nxt_s = target_s;
        nib_nxt_s   = 2'd0;
      end else begin
        case (state_r)
          ENTRY_A: begin
            al_nxt_s  = set_nibble(al_r, nib_r, sw_digit);
            nib_nxt_s = nib_r + 2'd1;   // wraps 3 -> 0
          end
          ENTRY_B: begin
            bl_nxt_s  = set_nibble(bl_r, nib_r, sw_digit);
            nib_nxt_s = nib_r + 2'd1;
          end
          default: begin
            nib_nxt_s = nib_r;          // SHOW_RES: Enter is ignored
          end
        endcase
      end
    end else begin
      state_nxt_s = state_r;
    end
  end

  // FSM state, nibble index and operand latch registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ENTRY_A;
      nib_r   <= 2'd0;
      al_r    <= 16'h0000;
      bl_r    <= 16'h0000;
    end else begin
      state_r <= state_nxt_s;
      nib_r   <= nib_nxt_s;
      al_r    <= al_nxt_s;
      bl_r    <= bl_nxt_s;
    end
  end

  // ---------------------------------------------------------------------------
  // ALU hand-off and display
  // ---------------------------------------------------------------------------
  logic [31:0] a_out_r;
  logic [31:0] b_out_r;
  logic [2:0]  oper_out_r;
  logic        run_pulse_r;
  logic [15:0] disp_r;

  // Operand/opcode registers load on Run from the pre-edge latch values, so an
  // Enter write in the same cycle is not visible to this Run.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_out_r     <= 32'h0000_0000;
      b_out_r     <= 32'h0000_0000;
      oper_out_r  <= 3'd0;
      run_pulse_r <= 1'b0;
    end else begin
      run_pulse_r <= run_evt_s;
      if (run_evt_s) begin
        a_out_r    <= ext_operand(al_r);
        b_out_r    <= ext_operand(bl_r);
        oper_out_r <= sw_oper;
      end else begin
        a_out_r    <= a_out_r;
        b_out_r    <= b_out_r;
        oper_out_r <= oper_out_r;
      end
    end
  end

  // Display register: shows the latch being edited, or the ALU result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      disp_r <= 16'h0000;
    end else begin
      case (state_r)
        ENTRY_A: disp_r <= al_r;
        ENTRY_B: disp_r <= bl_r;
        default: disp_r <= alu_result;
      endcase
    end
  end

  assign a_out     = a_out_r;
  assign b_out     = b_out_r;
  assign oper_out  = oper_out_r;
  assign run_pulse = run_pulse_r;
  assign disp_data = disp_r;
  assign mode      = state_r;
  assign nib_idx   = nib_r;

endmodule

// File: doc/operand_entry.md
OPERAND_ENTRY -- requirements
Module: operand_entry

Interface
REQ-001 Parameter DB_CYCLES, default 50000: consecutive stable cycles required to accept a key level change.
REQ-002 Parameter DB_W, default 16: debounce counter width; DB_CYCLES < 2^DB_W.
REQ-003 clk  input  1  system clock, 50 MHz; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-005 key_enter_n  input  1  raw Enter push-button, asynchronous, low = pressed.
REQ-006 key_run_n  input  1  raw Run push-button, asynchronous, low = pressed.
REQ-007 sw_sel  input  2  mode select: 0 = operand A, 1 = operand B, 2 or 3 = show result.
REQ-008 sw_digit  input  4  hex nibble to enter.
REQ-009 sw_oper  input  3  ALU opcode to issue on Run.
REQ-010 alu_result  input  16  result from the downstream ALU, used for display only.
REQ-011 a_out  output  32  operand A presented to the ALU.
REQ-012 b_out  output  32  operand B presented to the ALU.
REQ-013 oper_out  output  3  opcode presented to the ALU.
REQ-014 run_pulse  output  1  one-cycle strobe; a_out, b_out and oper_out changed on this edge.
REQ-015 disp_data  output  16  value for the four hex digits.
REQ-016 mode  output  2  current FSM state encoding: 0 = ENTRY_A, 1 = ENTRY_B, 2 = SHOW_RES.
REQ-017 nib_idx  output  2  index of the next nibble to be written.

Function
REQ-018 Each key SHALL pass through a 2-flop synchronizer before any other logic.
REQ-019 Each key SHALL have a debouncer that updates its debounced level only after the synchronized level differs from it for DB_CYCLES consecutive cycles; any glitch restarts the count at 0.
REQ-020 A press event SHALL be a single-cycle pulse on the debounced 1->0 transition: exactly one per press, none on release, none while held.
REQ-021 The press event SHALL be asserted exactly DB_CYCLES+3 cycles after a clean raw falling edge.
REQ-022 The FSM states SHALL be ENTRY_A, ENTRY_B and SHOW_RES; sw_sel 2 and 3 both map to SHOW_RES.
REQ-023 On an Enter event where sw_sel maps to a state other than the current one: the FSM moves to that state, nib_idx is set to 0, and no operand latch is written.
REQ-024 On an Enter event where sw_sel maps to the current state ENTRY_A (ENTRY_B): sw_digit is written to nibble nib_idx of latch AL (BL), bits [4i+3:4i], and nib_idx increments.
REQ-025 nib_idx SHALL wrap from 3 to 0; the fifth Enter event overwrites nibble 0.
REQ-026 An Enter event in SHOW_RES with an unchanged selection SHALL have no effect.
REQ-027 On a Run event, on the same edge: a_out and b_out are loaded from the extended AL and BL, oper_out from sw_oper, and run_pulse is 1 for exactly one cycle.
REQ-028 When Enter and Run events occur in the same cycle, Run SHALL capture the AL and BL values held before that edge; the Enter write also completes.
REQ-029 disp_data SHALL be registered with 1-cycle latency and equal AL, BL or alu_result for ENTRY_A, ENTRY_B or SHOW_RES respectively.
REQ-030 a_out, b_out and oper_out SHALL hold their values between Run events, regardless of subsequent entry activity.

Reset
REQ-031 With rst_n low at a rising edge, the block SHALL load: AL, BL, a_out, b_out = 0; oper_out = 0; run_pulse = 0; disp_data = 0; mode = ENTRY_A; nib_idx = 0; synchronizers and debounced levels = 1 (released); debounce counters = 0.
REQ-032 Reset asserted mid-debounce SHALL discard the partial count.
REQ-033 A key held low across reset release SHALL produce one event DB_CYCLES+3 cycles after release.

Configuration
REQ-034 Macro OPERAND_SIGN_EXT_EN: when defined, a_out and b_out SHALL be AL and BL sign-extended from bit 15.
REQ-035 When OPERAND_SIGN_EXT_EN is undefined, a_out and b_out SHALL be AL and BL zero-extended to 32 bits.

Verification (DB_CYCLES=4)
REQ-036 sw_sel=0; Enter with digits 1,2,3,4 -> AL=16'h4321, nib_idx=0, disp_data=16'h4321.
REQ-037 Continuing REQ-036: a fifth Enter with digit F -> AL=16'h432F.
REQ-038 Enter held low for 3 cycles, then released -> no event, AL unchanged; one clean press held 100 cycles -> exactly one write.
REQ-039 AL=16'h8001, BL=16'h0002, sw_oper=3'b001, Run -> run_pulse high for 1 cycle; b_out=32'h00000002; oper_out=3'b001; a_out=32'hFFFF8001 with the macro defined, 32'h00008001 without.
REQ-040 In ENTRY_A with nib_idx=2: sw_sel=1 + Enter -> mode=ENTRY_B, nib_idx=0, BL unchanged; sw_sel=2 + Enter, alu_result=16'hBEEF -> disp_data=16'hBEEF one cycle later.
REQ-041 rst_n low for 1 cycle after the REQ-036 entries -> all outputs 0, mode=ENTRY_A; same-cycle Enter and Run -> a_out holds the AL value from before the write.
